// File: rtl/char_motion_engine.sv
// Frame-tick driven character mover: walk, charge/launch jump, gravity, landing stun.
// Optional: define WALL_BOUNCE_EN to reflect vx on airborne side collisions instead of stopping.
module char_motion_engine #(
   parameter int unsigned POS_W      = 10,
   parameter int unsigned VEL_W      = 8,
   parameter int unsigned X_START    = 320,
   parameter int unsigned Y_START    = 410,
   parameter int unsigned X_MIN      = 110,
   parameter int unsigned X_MAX      = 432,
   parameter int unsigned Y_MIN      = 0,
   parameter int unsigned Y_MAX      = 479,
   parameter int unsigned CHAR_SIZE  = 4,
   parameter int unsigned X_STEP     = 1,
   parameter int unsigned X_JUMP     = 2,
   parameter int unsigned CHARGE_MAX = 15,
   parameter int unsigned JUMP_MULT  = 1,
   parameter int unsigned GRAVITY    = 1,
   parameter int unsigned VY_MAX     = 12,
   parameter int unsigned LAND_TICKS = 3,
   parameter logic [7:0]  KEY_JUMP   = 8'h2C,
   parameter logic [7:0]  KEY_LEFT   = 8'h04,
   parameter logic [7:0]  KEY_RIGHT  = 8'h07
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             frame_tick,
   input  logic [7:0]       keycode0,
   input  logic [7:0]       keycode1,
   input  logic             left_collide,
   input  logic             right_collide,
   input  logic             top_collide,
   input  logic             bottom_collide,
   output logic [POS_W-1:0] char_x,
   output logic [POS_W-1:0] char_y,
   output logic [POS_W-1:0] char_size,
   output logic [3:0]       charge_level,
   output logic             airborne,
   output logic [3:0]       HEXstate
);

   localparam int unsigned SW  = POS_W + 2;
   localparam int unsigned VGW = VEL_W + 2;
   localparam int unsigned LCW = 8;
   localparam int          VMAG = 2 ** (VEL_W - 1);

   localparam logic signed [SW-1:0]    X_MIN_S   = $signed(SW'(X_MIN));
   localparam logic signed [SW-1:0]    X_MAX_S   = $signed(SW'(X_MAX));
   localparam logic signed [SW-1:0]    Y_MIN_S   = $signed(SW'(Y_MIN));
   localparam logic signed [SW-1:0]    Y_MAX_S   = $signed(SW'(Y_MAX));
   localparam logic signed [VGW-1:0]   VY_MAX_S  = $signed(VGW'(VY_MAX));
   localparam logic signed [VGW-1:0]   GRAV_S    = $signed(VGW'(GRAVITY));
   localparam logic signed [VEL_W-1:0] VX_JUMP_S = $signed(VEL_W'(X_JUMP));
   localparam logic signed [VEL_W-1:0] VMIN_S    = $signed(VEL_W'(VMAG));
   localparam logic                    LAND_NONE = (LAND_TICKS == 0);
   localparam logic [LCW-1:0]          LAND_LAST = (LAND_TICKS == 0) ? '0 : LCW'(LAND_TICKS - 1);

   typedef enum logic [1:0] {
      S_GROUND = 2'd0,
      S_CHARGE = 2'd1,
      S_AIR    = 2'd2,
      S_LAND   = 2'd3
   } state_t;

   state_t                  state;
   logic signed [VEL_W-1:0] vx, vy;
   logic [LCW-1:0]          land_cnt;

   logic                    jump_h, left_h, right_h, left_only, right_only;
   logic signed [VEL_W-1:0] vx_side, vy_ceil, vy_grav, vy_launch;
   logic signed [VGW-1:0]   vy_wide;
   logic signed [SW-1:0]    x_sum, y_sum;
   logic [POS_W-1:0]        x_clamp, y_clamp, walk_l, walk_r;
   logic                    land_pre;
   int                      launch_mag;

   assign char_size = POS_W'(CHAR_SIZE);

   // Key decode and all airborne/launch arithmetic for the current registers
   always_comb begin
      jump_h     = (keycode0 == KEY_JUMP)  || (keycode1 == KEY_JUMP);
      left_h     = (keycode0 == KEY_LEFT)  || (keycode1 == KEY_LEFT);
      right_h    = (keycode0 == KEY_RIGHT) || (keycode1 == KEY_RIGHT);
      left_only  = left_h && !right_h;
      right_only = right_h && !left_h;

      vx_side = vx;
      if ((left_collide && vx[VEL_W-1]) || (right_collide && !vx[VEL_W-1] && (vx != '0))) begin
`ifdef WALL_BOUNCE_EN
         vx_side = -vx;
`else
         vx_side = '0;
`endif
      end
      vy_ceil = (top_collide && vy[VEL_W-1]) ? '0 : vy;

      // Sums at POS_W+2 signed so the clamp sees true under/overflow
      x_sum = {2'b00, char_x} + {{(SW - VEL_W){vx_side[VEL_W-1]}}, vx_side};
      y_sum = {2'b00, char_y} + {{(SW - VEL_W){vy_ceil[VEL_W-1]}}, vy_ceil};

      if (x_sum < X_MIN_S)      x_clamp = POS_W'(X_MIN);
      else if (x_sum > X_MAX_S) x_clamp = POS_W'(X_MAX);
      else                      x_clamp = POS_W'(x_sum);

      if (y_sum < Y_MIN_S)      y_clamp = POS_W'(Y_MIN);
      else if (y_sum > Y_MAX_S) y_clamp = POS_W'(Y_MAX);
      else                      y_clamp = POS_W'(y_sum);

      vy_wide = {{2{vy_ceil[VEL_W-1]}}, vy_ceil} + GRAV_S;
      vy_grav = (vy_wide > VY_MAX_S) ? VEL_W'(VY_MAX) : VEL_W'(vy_wide);

      launch_mag = int'(charge_level) * int'(JUMP_MULT);
      vy_launch  = (launch_mag >= VMAG) ? VMIN_S : VEL_W'(-launch_mag);

      land_pre = bottom_collide && !vy[VEL_W-1];

      walk_l = (char_x >= POS_W'(X_MIN + X_STEP)) ? char_x - POS_W'(X_STEP) : POS_W'(X_MIN);
      walk_r = (char_x <= POS_W'(X_MAX - X_STEP)) ? char_x + POS_W'(X_STEP) : POS_W'(X_MAX);
   end

   // Motion FSM; every register advances only on frame_tick
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state        <= S_GROUND;
         char_x       <= POS_W'(X_START);
         char_y       <= POS_W'(Y_START);
         vx           <= '0;
         vy           <= '0;
         charge_level <= '0;
         land_cnt     <= '0;
         airborne     <= 1'b0;
         HEXstate     <= 4'd0;
      end else if (frame_tick) begin
         case (state)
            S_GROUND: begin
               if (!bottom_collide) begin
                  state    <= S_AIR;
                  vx       <= '0;
                  vy       <= '0;
                  airborne <= 1'b1;
                  HEXstate <= 4'd2;
               end else if (jump_h) begin
                  state        <= S_CHARGE;
                  charge_level <= '0;
                  HEXstate     <= 4'd1;
               end else if (left_only && !left_collide && (char_x > POS_W'(X_MIN))) begin
                  char_x <= walk_l;
               end else if (right_only && !right_collide && (char_x < POS_W'(X_MAX))) begin
                  char_x <= walk_r;
               end
            end
            S_CHARGE: begin
               if (jump_h) begin
                  if (charge_level < 4'(CHARGE_MAX)) charge_level <= charge_level + 4'd1;
               end else begin
                  state        <= S_AIR;
                  airborne     <= 1'b1;
                  HEXstate     <= 4'd2;
                  vy           <= vy_launch;
                  vx           <= left_only ? -VX_JUMP_S : (right_only ? VX_JUMP_S : '0);
                  charge_level <= '0;
               end
            end
            S_AIR: begin
               if (land_pre) begin
                  state    <= S_LAND;
                  vx       <= '0;
                  vy       <= '0;
                  land_cnt <= '0;
                  airborne <= 1'b0;
                  HEXstate <= 4'd3;
               end else begin
                  char_x <= x_clamp;
                  char_y <= y_clamp;
                  if (y_clamp == POS_W'(Y_MAX)) begin
                     state    <= S_LAND;
                     vx       <= '0;
                     vy       <= '0;
                     land_cnt <= '0;
                     airborne <= 1'b0;
                     HEXstate <= 4'd3;
                  end else begin
                     vx <= vx_side;
                     vy <= vy_grav;
                  end
               end
            end
            S_LAND: begin
               if (LAND_NONE || (land_cnt == LAND_LAST)) begin
                  state    <= S_GROUND;
                  land_cnt <= '0;
                  HEXstate <= 4'd0;
               end else begin
                  land_cnt <= land_cnt + LCW'(1);
               end
            end
            default: begin
               state    <= S_GROUND;
               HEXstate <= 4'd0;
               airborne <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_char_motion_engine.sv
// Directed bench for char_motion_engine: reset, walking, charge/launch/flight/landing, saturation, wall hit, tick gating.
module tb_char_motion_engine;

   logic       CLK = 1'b0;
   logic       Reset = 1'b0;
   logic       frame_tick = 1'b0;
   logic [7:0] keycode0 = 8'h00;
   logic [7:0] keycode1 = 8'h00;
   logic       left_collide = 1'b0;
   logic       right_collide = 1'b0;
   logic       top_collide = 1'b0;
   logic       bottom_collide = 1'b1;
   logic [9:0] char_x, char_y, char_size;
   logic [3:0] charge_level;
   logic       airborne;
   logic [3:0] HEXstate;

   int n_checks = 0;
   int n_fail   = 0;
   logic floor_en = 1'b0;
   logic [31:0] wall_x2, wall_x3;

   char_motion_engine dut (
      .CLK(CLK), .Reset(Reset), .frame_tick(frame_tick),
      .keycode0(keycode0), .keycode1(keycode1),
      .left_collide(left_collide), .right_collide(right_collide),
      .top_collide(top_collide), .bottom_collide(bottom_collide),
      .char_x(char_x), .char_y(char_y), .char_size(char_size),
      .charge_level(charge_level), .airborne(airborne), .HEXstate(HEXstate)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1ms;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      if (floor_en) bottom_collide = (char_y >= 10'd410);
      frame_tick = 1'b1;
      @(posedge CLK);
      #1;
      frame_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      keycode0 = 8'h00; keycode1 = 8'h00;
      left_collide = 1'b0; right_collide = 1'b0; top_collide = 1'b0;
      bottom_collide = 1'b1; floor_en = 1'b0;
      Reset = 1'b0;
      @(posedge CLK);
      #1;
      Reset = 1'b1;
   endtask

   initial begin
`ifdef WALL_BOUNCE_EN
      wall_x2 = 320; wall_x3 = 318;
`else
      wall_x2 = 322; wall_x3 = 322;
`endif
      repeat (2) @(posedge CLK);
      #1;
      Reset = 1'b1;

      // Reset state
      check("rst_x", 32'(char_x), 320);
      check("rst_y", 32'(char_y), 410);
      check("rst_hex", 32'(HEXstate), 0);
      check("rst_charge", 32'(charge_level), 0);
      check("rst_air", 32'(airborne), 0);
      check("size", 32'(char_size), 4);

      // Walking
      keycode0 = 8'h07;
      ticks(5);
      check("walk_right", 32'(char_x), 325);
      do_reset();
      keycode0 = 8'h07; right_collide = 1'b1;
      ticks(5);
      check("walk_right_blocked", 32'(char_x), 320);
      do_reset();
      keycode0 = 8'h04; keycode1 = 8'h07;
      ticks(3);
      check("walk_both", 32'(char_x), 320);
      keycode1 = 8'h00;
      ticks(215);
      check("walk_left_min", 32'(char_x), 110);

      // Walk off a ledge takes priority over jump
      keycode0 = 8'h2C; bottom_collide = 1'b0;
      tick();
      check("ledge_hex", 32'(HEXstate), 2);
      check("ledge_air", 32'(airborne), 1);

      // Full jump with right arrow on release, floor at y=410
      do_reset();
      floor_en = 1'b1;
      keycode0 = 8'h2C;
      tick();
      check("charge_enter_hex", 32'(HEXstate), 1);
      check("charge_enter_lvl", 32'(charge_level), 0);
      ticks(10);
      check("charge_10", 32'(charge_level), 10);
      keycode0 = 8'h07;
      tick();
      check("launch_hex", 32'(HEXstate), 2);
      check("launch_x", 32'(char_x), 320);
      check("launch_y", 32'(char_y), 410);
      check("launch_charge", 32'(charge_level), 0);
      tick();
      check("air1_x", 32'(char_x), 322);
      check("air1_y", 32'(char_y), 400);
      ticks(9);
      check("apex_y", 32'(char_y), 355);
      check("apex_x", 32'(char_x), 340);
      ticks(11);
      check("fall_y", 32'(char_y), 410);
      check("fall_x", 32'(char_x), 362);
      check("fall_hex", 32'(HEXstate), 2);
      tick();
      check("land_hex", 32'(HEXstate), 3);
      check("land_y", 32'(char_y), 410);
      check("land_x", 32'(char_x), 362);
      check("land_air", 32'(airborne), 0);
      ticks(2);
      check("land_stun", 32'(HEXstate), 3);
      tick();
      check("ground_again", 32'(HEXstate), 0);

      // Reset in mid-flight
      do_reset();
      floor_en = 1'b1;
      keycode0 = 8'h2C;
      ticks(11);
      keycode0 = 8'h00;
      tick();
      ticks(5);
      check("mid_y", 32'(char_y), 370);
      check("mid_hex", 32'(HEXstate), 2);
      do_reset();
      check("mid_rst_x", 32'(char_x), 320);
      check("mid_rst_y", 32'(char_y), 410);
      check("mid_rst_hex", 32'(HEXstate), 0);
      check("mid_rst_charge", 32'(charge_level), 0);
      check("mid_rst_air", 32'(airborne), 0);

      // Charge saturation and full-strength launch
      floor_en = 1'b1;
      keycode0 = 8'h2C;
      tick();
      ticks(30);
      check("charge_sat", 32'(charge_level), 15);
      keycode0 = 8'h00;
      tick();
      tick();
      check("sat_launch_y", 32'(char_y), 395);
      check("sat_launch_x", 32'(char_x), 320);

      // Right wall hit during flight
      do_reset();
      floor_en = 1'b1;
      keycode0 = 8'h2C;
      ticks(3);
      check("wall_charge", 32'(charge_level), 2);
      keycode0 = 8'h07;
      tick();
      tick();
      check("wall_x1", 32'(char_x), 322);
      check("wall_y1", 32'(char_y), 408);
      right_collide = 1'b1;
      tick();
      check("wall_x2", 32'(char_x), wall_x2);
      check("wall_y2", 32'(char_y), 407);
      right_collide = 1'b0;
      tick();
      check("wall_x3", 32'(char_x), wall_x3);
      check("wall_y3", 32'(char_y), 407);

      // No motion without frame_tick
      floor_en = 1'b0;
      for (int i = 0; i < 100; i++) begin
         keycode0       = 8'($urandom);
         keycode1       = (i % 3 == 0) ? 8'h2C : 8'($urandom);
         left_collide   = 1'($urandom);
         right_collide  = 1'($urandom);
         top_collide    = 1'($urandom);
         bottom_collide = 1'($urandom);
         @(posedge CLK);
         #1;
      end
      check("hold_x", 32'(char_x), wall_x3);
      check("hold_y", 32'(char_y), 407);
      check("hold_hex", 32'(HEXstate), 2);
      check("hold_charge", 32'(charge_level), 0);
      check("hold_air", 32'(airborne), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/char_motion_engine.md
Name: char_motion_engine

Overview:
Parametrised successor to the single-screen character mover. It takes the charge/launch jump mechanic, gravity, walking and collision response that were previously spread across fixed counters and a separate controller, and places them in one frame-tick-driven state machine. Position width, playfield bounds, start point, charge depth, jump scaling, gravity, landing stun and key bindings are all parameters. It sits between the keyboard keycode registers and the screen/collision logic, and feeds the sprite renderer with char_x/char_y/char_size.

Parameters:
POS_W, 10, width of position outputs
VEL_W, 8, width of signed velocity registers
X_START, 320, reset/respawn X (centre)
Y_START, 410, reset/respawn Y (centre)
X_MIN, 110, leftmost legal centre X
X_MAX, 432, rightmost legal centre X
Y_MIN, 0, topmost legal centre Y
Y_MAX, 479, bottommost legal centre Y
CHAR_SIZE, 4, half-size driven on char_size
X_STEP, 1, walk step per tick
X_JUMP, 2, horizontal speed magnitude of a directed jump
CHARGE_MAX, 15, charge saturation value
JUMP_MULT, 1, launch vy = -(charge*JUMP_MULT)
GRAVITY, 1, vy increment per airborne tick
VY_MAX, 12, terminal fall speed
LAND_TICKS, 3, stun ticks after landing
KEY_JUMP, 8'h2C, space
KEY_LEFT, 8'h04, A
KEY_RIGHT, 8'h07, D

Ports:
CLK  in  1  system clock
Reset  in  1  synchronous, active-low reset
frame_tick  in  1  one-cycle strobe per video frame; all motion is gated by it
keycode0  in  8  first pressed key
keycode1  in  8  second pressed key
left_collide  in  1  wall contact on the left
right_collide  in  1  wall contact on the right
top_collide  in  1  ceiling contact
bottom_collide  in  1  floor contact
char_x  out  POS_W  centre X
char_y  out  POS_W  centre Y
char_size  out  POS_W  constant CHAR_SIZE
charge_level  out  4  current charge
airborne  out  1  high in AIRBORNE
HEXstate  out  4  encoded state: GROUND=0, CHARGE=1, AIRBORNE=2, LAND=3

Behaviour:
- A key is "held" if keycode0 or keycode1 equals its code.
- Reset==0 at a CLK edge: char_x=X_START, char_y=Y_START, vx=vy=0, charge=0, land_cnt=0, state=GROUND, airborne=0, HEXstate=0. This applies mid-jump as well.
- All registers are updated only at edges where frame_tick=1. Outputs are registered and visible the cycle after that edge.
- GROUND:
  - Jump held: go to CHARGE, charge=0, no X motion.
  - Otherwise, left-only held and !left_collide and x>X_MIN: x -= X_STEP. Right is symmetric with X_MAX.
  - Left and right both held: no motion.
  - !bottom_collide: go to AIRBORNE with vx=0, vy=0 (walked off a ledge). This check has priority over jump.
- CHARGE:
  - Jump held: charge = min(charge+1, CHARGE_MAX). Arrows are ignored for motion.
  - Jump released: go to AIRBORNE, vy = -(charge*JUMP_MULT), saturated to the signed VEL_W range. vx = -X_JUMP for left-only, +X_JUMP for right-only, else 0. Charge is cleared. Position does not change on this tick.
- AIRBORNE, each tick in this order:
  - Side handling: left_collide with vx<0, or right_collide with vx>0, sets vx=0.
  - Ceiling handling: top_collide with vy<0 sets vy=0.
  - x += vx, clamped to [X_MIN, X_MAX]. y += vy, clamped to [Y_MIN, Y_MAX].
  - vy = min(vy+GRAVITY, VY_MAX).
  - Landing: bottom_collide with vy>=0 (sampled before the update), or y reaching Y_MAX, goes to LAND. vx=vy=0 and the position is held.
- LAND: keys are ignored. land_cnt increments each tick; when land_cnt==LAND_TICKS-1, go to GROUND and clear land_cnt. LAND_TICKS=0 returns to GROUND on the next tick.
- Arithmetic: positions are unsigned POS_W and velocities signed VEL_W. Sums are computed at POS_W+2 bits signed, then clamped, so there is no wrap-around at 0 or the maximum.
- frame_tick=0: every register holds. Key changes between ticks are not latched.

Optional Feature:
WALL_BOUNCE_EN
- Defined: an AIRBORNE side collision sets vx=-vx (reflect) instead of 0. A reflect on the same tick as landing is discarded.
- Undefined: vx=0 on side collision, as above.

Test Plan:
- Reset=0 mid-flight (y=370, state=2) -> next cycle char_x=320, char_y=410, HEXstate=0, charge_level=0.
- GROUND, keycode0=8'h07 for 5 ticks, bottom_collide=1 -> char_x 320->325; with right_collide=1 -> x stays 320.
- Space held 10 ticks -> charge_level=10. Release with D held, floor model bottom_collide=(y>=410) -> first airborne tick y=400, x=322. Apex y=355 after 10 ticks. LAND after returning to y=410, then GROUND after 3 ticks.
- Space held 30 ticks -> charge_level saturates at 15; launch vy=-15.
- Jump with vx=+2, right_collide asserted mid-air -> vx=0 (macro undefined) or vx=-2 (WALL_BOUNCE_EN), x decreasing on the following ticks.
- Key and collision inputs toggled with frame_tick=0 for 100 cycles -> no output change.
